regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the OpenMIPS core, superseding the fixed 2-read/1-write `RegFile`. It serves NUM_RD combinational read ports and NUM_WR synchronous write ports, with prioritised same-cycle write-to-read bypass and a hard-wired zero register. After reset, a sequential clear engine zeroes the array one entry per cycle and reports `busy` until the clear completes. It sits between the decode stage (reads) and the write-back stage (writes). A second write port is provided for dual-issue / HI-LO-style writes.

---
 rtl/regfile_mp_pkg.sv | 15 +
 rtl/regfile_mp_bypass.sv | 34 +++
 rtl/regfile_mp.sv | 118 +++++++++++
 tb/tb_regfile_mp.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared constants and FSM encoding for the multi-port register file.
package regfile_mp_pkg;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic        WRITE_ENABLE = 1'b1;
    localparam logic        READ_ENABLE  = 1'b1;
    // This block's reset is active when the reset input is low
    localparam logic        RST_ACTIVE   = 1'b0;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_mp_bypass.sv
// One read port: gating, zero register, and prioritised write-to-read bypass.
module rf_bypass_mux
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_WR  = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                     i_ready,
    input  logic                     i_re,
    input  logic [ADDR_W-1:0]        i_raddr,
    input  logic [NUM_WR-1:0]        i_we,
    input  logic [NUM_WR*ADDR_W-1:0] i_waddr,
    input  logic [NUM_WR*DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0]        i_arr_data,
    output logic [DATA_W-1:0]        o_rdata
);

    // Later ports overwrite earlier matches, so the highest-index writer wins
    always_comb begin
        o_rdata = DATA_W'(ZERO_WORD);
        if (i_ready && (i_re == READ_ENABLE) &&
            !((ZERO_R0 != 0) && (i_raddr == '0))) begin
            o_rdata = i_arr_data;
            for (int k = 0; k < NUM_WR; k++) begin
                if ((i_we[k] == WRITE_ENABLE) &&
                    (i_waddr[k*ADDR_W +: ADDR_W] == i_raddr))
                    o_rdata = i_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset sequential clear engine.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int NUM_WR  = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_WR-1:0]        i_we,
    input  logic [NUM_WR*ADDR_W-1:0] i_waddr,
    input  logic [NUM_WR*DATA_W-1:0] i_wdata,
    input  logic [NUM_RD-1:0]        i_re,
    input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
    output logic [NUM_RD*DATA_W-1:0] o_rdata,
    output logic                     o_busy,
    output logic                     o_wr_conflict
);

    localparam int DEPTH = 2**ADDR_W;

    rf_state_e          r_state;
    logic [ADDR_W-1:0]  r_clr_cnt;
    logic               r_busy;
    logic               r_wr_conflict;
    logic [DATA_W-1:0]  r_regs [DEPTH];

    logic               w_ready;
    logic               w_conflict;

    assign w_ready       = (r_state == RF_READY);
    assign o_busy        = r_busy;
    assign o_wr_conflict = r_wr_conflict;

    // Any two enabled write ports aiming at the same non-zero entry
    always_comb begin
        w_conflict = 1'b0;
        for (int a = 0; a < NUM_WR; a++) begin
            for (int b = a + 1; b < NUM_WR; b++) begin
                if (i_we[a] && i_we[b] &&
                    (i_waddr[a*ADDR_W +: ADDR_W] == i_waddr[b*ADDR_W +: ADDR_W]) &&
                    (i_waddr[a*ADDR_W +: ADDR_W] != '0))
                    w_conflict = 1'b1;
            end
        end
    end

    // Control FSM: clear sweep after reset, then normal operation
    always_ff @(posedge i_clk) begin
        if (i_rst == RST_ACTIVE) begin
            r_state       <= RF_CLEAR;
            r_clr_cnt     <= '0;
            r_busy        <= 1'b1;
            r_wr_conflict <= 1'b0;
        end else begin
            case (r_state)
                RF_CLEAR: begin
                    r_wr_conflict <= 1'b0;
                    r_clr_cnt     <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state <= RF_READY;
                        r_busy  <= 1'b0;
                    end
                end
                RF_READY: begin
                    r_wr_conflict <= w_conflict;
                end
                default: begin
                    r_state       <= RF_CLEAR;
                    r_clr_cnt     <= '0;
                    r_busy        <= 1'b1;
                    r_wr_conflict <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset of its own; the clear sweep is the only zeroing path
    always_ff @(posedge i_clk) begin
        if (i_rst != RST_ACTIVE) begin
            if (r_state == RF_CLEAR) begin
                r_regs[r_clr_cnt] <= DATA_W'(ZERO_WORD);
            end else begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if ((i_we[k] == WRITE_ENABLE) &&
                        !((ZERO_R0 != 0) && (i_waddr[k*ADDR_W +: ADDR_W] == '0)))
                        r_regs[i_waddr[k*ADDR_W +: ADDR_W]] <= i_wdata[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [DATA_W-1:0] w_arr_data;

        assign w_arr_data = r_regs[i_raddr[j*ADDR_W +: ADDR_W]];

        rf_bypass_mux #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .NUM_WR  (NUM_WR),
            .ZERO_R0 (ZERO_R0)
        ) u_byp (
            .i_ready    (w_ready),
            .i_re       (i_re[j]),
            .i_raddr    (i_raddr[j*ADDR_W +: ADDR_W]),
            .i_we       (i_we),
            .i_waddr    (i_waddr),
            .i_wdata    (i_wdata),
            .i_arr_data (w_arr_data),
            .o_rdata    (o_rdata[j*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp with a behavioural register-file model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  we = '0;
    logic [9:0]  waddr = '0;
    logic [63:0] wdata = '0;
    logic [1:0]  re = '0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata;
    logic        busy;
    logic        wr_conflict;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        int          kind;   // 0 rdata, 1 busy, 2 wr_conflict
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];

    // behavioural model
    logic [31:0] mdl [32];
    bit          m_ready = 0;
    int          m_clr_left = 32;
    bit          m_conf = 0;

    regfile_mp dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_we          (we),
        .i_waddr       (waddr),
        .i_wdata       (wdata),
        .i_re          (re),
        .i_raddr       (raddr),
        .o_rdata       (rdata),
        .o_busy        (busy),
        .o_wr_conflict (wr_conflict)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mdl_read(input bit r_en, input int ra,
                                             input logic [1:0] w_e, input int wa0, input int wa1,
                                             input logic [31:0] wd0, input logic [31:0] wd1);
        logic [31:0] v;
        if (!m_ready || !r_en || ra == 0) return 32'h0;
        v = mdl[ra];
        if (w_e[0] && wa0 == ra) v = wd0;
        if (w_e[1] && wa1 == ra) v = wd1;
        return v;
    endfunction

    task automatic push(input int kind, input int port, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc = cyc; e.kind = kind; e.port = port; e.val = val; e.name = name;
        sb.push_back(e);
    endtask

    // One clock of stimulus: drive, record expectations, then advance the model past the edge
    task automatic step(input logic r, input logic [1:0] w_e, input int wa0, input int wa1,
                        input logic [31:0] wd0, input logic [31:0] wd1,
                        input logic [1:0] r_e, input int ra0, input int ra1, input string tag);
        @(posedge clk); #1;
        rst = r; we = w_e;
        waddr = {5'(wa1), 5'(wa0)};
        wdata = {wd1, wd0};
        re = r_e;
        raddr = {5'(ra1), 5'(ra0)};
        push(0, 0, mdl_read(r_e[0], ra0, w_e, wa0, wa1, wd0, wd1), {tag, "_rd0"});
        push(0, 1, mdl_read(r_e[1], ra1, w_e, wa0, wa1, wd0, wd1), {tag, "_rd1"});
        push(1, 0, {31'h0, !m_ready}, {tag, "_busy"});
        push(2, 0, {31'h0, m_conf}, {tag, "_conflict"});
        if (!r) begin
            m_ready = 0; m_clr_left = 32; m_conf = 0;
        end else if (!m_ready) begin
            mdl[32 - m_clr_left] = 32'h0;
            m_clr_left--;
            if (m_clr_left == 0) m_ready = 1;
            m_conf = 0;
        end else begin
            if (w_e[0] && wa0 != 0) mdl[wa0] = wd0;
            if (w_e[1] && wa1 != 0) mdl[wa1] = wd1;
            m_conf = w_e[0] && w_e[1] && (wa0 == wa1) && (wa0 != 0);
        end
    endtask

    task automatic rand_step(input logic r, input int amax, input string tag);
        step(r, 2'($urandom), $urandom_range(0, amax), $urandom_range(0, amax),
             $urandom, $urandom, 2'($urandom), $urandom_range(0, amax), $urandom_range(0, amax), tag);
    endtask

    task automatic readback(input string tag);
        for (int i = 0; i < 16; i++) step(1, 2'b00, 0, 0, 0, 0, 2'b11, 2*i, 2*i+1, tag);
    endtask

    // Monitor: compare every expectation belonging to the current cycle
    always @(negedge clk) begin
        exp_t keep[$];
        logic [31:0] act;
        keep = {};
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc == cyc) begin
                case (sb[i].kind)
                    0:       act = rdata[sb[i].port*32 +: 32];
                    1:       act = {31'h0, busy};
                    default: act = {31'h0, wr_conflict};
                endcase
                checks++;
                if (act !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s (cycle %0d): got %h expected %h", sb[i].name, cyc, act, sb[i].val);
                end
            end else if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for cycle %0d never compared", sb[i].name, sb[i].cyc);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

        // reset held, then release and run the clear with random traffic (must be ignored)
        for (int i = 0; i < 3; i++) rand_step(0, 31, "reset");
        for (int i = 0; i < 34; i++) rand_step(1, 31, "clear");
        readback("post_clear");

        // write then read
        step(1, 2'b01, 5, 0, 32'hDEADBEEF, 0, 2'b00, 0, 0, "wr_r5");
        step(1, 2'b00, 0, 0, 0, 0, 2'b01, 5, 5, "rd_r5");

        // collision with bypass
        step(1, 2'b11, 7, 7, 32'h11, 32'h22, 2'b10, 0, 7, "bypass_r7");
        step(1, 2'b00, 0, 0, 0, 0, 2'b11, 7, 7, "r7_after");
        step(1, 2'b00, 0, 0, 0, 0, 2'b11, 5, 7, "conflict_drop");

        // zero register
        step(1, 2'b11, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 0, 0, "r0_wr");
        step(1, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0, "r0_rd");
        step(1, 2'b00, 0, 0, 0, 0, 2'b11, 0, 5, "r0_noconf");

        // random traffic, narrow address range for frequent collisions
        for (int i = 0; i < 200; i++) rand_step(1, 7, "rand_lo");
        for (int i = 0; i < 200; i++) rand_step(1, 31, "rand_all");

        // reset in the middle of a clear sweep
        for (int i = 0; i < 2; i++) rand_step(0, 31, "mid_rst_a");
        for (int i = 0; i < 10; i++) step(1, 2'b11, i + 1, 31 - i, $urandom, $urandom, 2'b11, i + 1, 31 - i, "clear_a");
        rand_step(0, 31, "mid_rst_b");
        for (int i = 0; i < 34; i++) step(1, 2'b11, (i % 31) + 1, 31 - (i % 31), $urandom, $urandom, 2'b11, i % 32, 31, "clear_b");
        readback("post_clear2");
        for (int i = 0; i < 100; i++) rand_step(1, 15, "rand_end");

        // let the monitor drain
        for (int i = 0; i < 3; i++) @(posedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
